// File: rtl/ralu_seq_pkg.sv
// Shared definitions for the RALU microsequencer: word layout, SEQ opcodes, store geometry.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package ralu_seq_pkg;

   // Store geometry
   localparam int UW    = 24;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int CW    = 4;

   // Microinstruction field positions, MSB to LSB
   localparam int S_MSB   = 23;
   localparam int S_LSB   = 20;
   localparam int M_BIT   = 19;
   localparam int P0_BIT  = 18;
   localparam int A_BIT   = 17;
   localparam int V_MSB   = 16;
   localparam int V_LSB   = 14;
   localparam int WR_BIT  = 13;
   localparam int ADR_MSB = 12;
   localparam int ADR_LSB = 10;
   localparam int ISR_BIT = 9;
   localparam int ISL_BIT = 8;
   localparam int SEQ_MSB = 7;
   localparam int SEQ_LSB = 5;
   localparam int TGT_MSB = 4;
   localparam int TGT_LSB = 0;

   // Datapath portion of the word (S down to ISL) is 16 bits wide
   localparam int DP_W = S_MSB - ISL_BIT + 1;

   // Sequencing opcodes
   typedef enum logic [2:0] {
      SEQ_NEXT  = 3'b000,
      SEQ_JMP   = 3'b001,
      SEQ_JC    = 3'b010,
      SEQ_JNC   = 3'b011,
      SEQ_LDCNT = 3'b100,
      SEQ_DJNZ  = 3'b101,
      SEQ_END   = 3'b110,
      SEQ_RSVD  = 3'b111
   } seq_op_t;

   // Sequencer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // RALU control word as presented on the outputs
   typedef struct packed {
      logic [3:0] s;
      logic       m;
      logic       p0;
      logic       a;
      logic [3:0] v;
      logic       wr;
      logic [2:0] adr;
      logic       isr;
      logic       isl;
   } ctrl_t;

   // Unpack the datapath slice (word bits S..ISL) into the control word.
   // v is only 3 bits in the word; the top output bit is always zero.
   function automatic ctrl_t decode_ctrl(input logic [DP_W-1:0] dp);
      ctrl_t c;
      c.s   = dp[S_MSB-ISL_BIT:S_LSB-ISL_BIT];
      c.m   = dp[M_BIT-ISL_BIT];
      c.p0  = dp[P0_BIT-ISL_BIT];
      c.a   = dp[A_BIT-ISL_BIT];
      c.v   = {1'b0, dp[V_MSB-ISL_BIT:V_LSB-ISL_BIT]};
      c.wr  = dp[WR_BIT-ISL_BIT];
      c.adr = dp[ADR_MSB-ISL_BIT:ADR_LSB-ISL_BIT];
      c.isr = dp[ISR_BIT-ISL_BIT];
      c.isl = dp[0];
      return c;
   endfunction

endpackage

// File: rtl/ralu_useq_mem.sv
// Microprogram store: DEPTH x UW words, one write port, one read port.
// Latency: write lands at the clock edge; read is combinational from the address.
// Backpressure: none; caller gates the write enable.
module ralu_useq_mem #(
   parameter int UW    = ralu_seq_pkg::UW,
   parameter int DEPTH = ralu_seq_pkg::DEPTH,
   parameter int AW    = ralu_seq_pkg::AW
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [UW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [UW-1:0] rdata_o
);

   // Store is deliberately not reset so a microprogram survives rst_n_i
   logic [UW-1:0] mem [DEPTH];

   // Synchronous write
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Asynchronous read so the current word decodes in the same cycle
   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ralu_seq.sv
// RALU microsequencer: IDLE/RUN FSM stepping a microprogram and issuing RALU control words.
// Latency: entry word issued the cycle after start_i; done_o pulses the cycle after END.
// Backpressure: none; start_i and store writes are only honoured while idle.
module ralu_seq #(
   parameter int UW    = ralu_seq_pkg::UW,
   parameter int DEPTH = ralu_seq_pkg::DEPTH
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          start_i,
   input  logic [4:0]    entry_i,
   input  logic          abort_i,
   input  logic          P4_i,
   input  logic          uc_we_i,
   input  logic [4:0]    uc_addr_i,
   input  logic [UW-1:0] uc_data_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [3:0]    S_o,
   output logic          M_o,
   output logic          P0_o,
   output logic          A_o,
   output logic [3:0]    v_o,
   output logic          wr_o,
   output logic [2:0]    adr_o,
   output logic          ISR_o,
   output logic          ISL_o
);

   import ralu_seq_pkg::*;

   state_t          state;
   logic [AW-1:0]   upc;
   logic [CW-1:0]   cnt;
   logic            done_q;

   logic [UW-1:0]   word;
   seq_op_t         seq;
   logic [AW-1:0]   tgt;
   logic [AW-1:0]   upc_inc;
   logic [CW-1:0]   cnt_dec;
   logic            run;
   logic            store_we;
   ctrl_t           ctrl;

   // Writes while running are dropped so the live program cannot change under us
   assign store_we = uc_we_i && (state == ST_IDLE);

   ralu_useq_mem #(
      .UW    (UW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (store_we),
      .waddr_i (uc_addr_i),
      .wdata_i (uc_data_i),
      .raddr_i (upc),
      .rdata_o (word)
   );

   // Field extraction and next-address helpers
   assign run     = (state == ST_RUN);
   assign seq     = seq_op_t'(word[SEQ_MSB:SEQ_LSB]);
   assign tgt     = word[TGT_MSB:TGT_LSB];
   assign upc_inc = upc + 5'd1;
   assign cnt_dec = cnt - 4'd1;

   // Control word decodes straight from the current word; forced to NOP when idle
   always_comb begin
      ctrl = '0;
      if (run) begin
         ctrl = decode_ctrl(word[S_MSB:ISL_BIT]);
      end
   end

   assign busy_o = run;
   assign done_o = done_q;
   assign S_o    = ctrl.s;
   assign M_o    = ctrl.m;
   assign P0_o   = ctrl.p0;
   assign A_o    = ctrl.a;
   assign v_o    = ctrl.v;
   assign wr_o   = ctrl.wr;
   assign adr_o  = ctrl.adr;
   assign ISR_o  = ctrl.isr;
   assign ISL_o  = ctrl.isl;

   // Sequencer FSM: state, micro-PC, loop counter and the registered done pulse
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= ST_IDLE;
         upc    <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  upc   <= entry_i;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Abort wins over whatever the current word asks for
               if (abort_i) begin
                  state <= ST_IDLE;
               end else begin
                  case (seq)
                     SEQ_NEXT: upc <= upc_inc;
                     SEQ_JMP:  upc <= tgt;
                     SEQ_JC:   upc <= P4_i ? tgt : upc_inc;
                     SEQ_JNC:  upc <= P4_i ? upc_inc : tgt;
                     SEQ_LDCNT: begin
                        cnt <= tgt[CW-1:0];
                        upc <= upc_inc;
                     end
                     SEQ_DJNZ: begin
                        // Counter wraps, so DJNZ at zero loops 15 more times
                        cnt <= cnt_dec;
                        upc <= (cnt_dec != '0) ? tgt : upc_inc;
                     end
                     default: begin
                        // END and the reserved code both finish the program
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                     end
                  endcase
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ralu_seq.sv
// Bench for ralu_seq: directed scenarios with literal expectations plus randomized programs
// checked every cycle against a behavioural model of the sequencer.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_ralu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  entry = '0;
   logic        abort = 1'b0;
   logic        p4 = 1'b0;
   logic        uc_we = 1'b0;
   logic [4:0]  uc_addr = '0;
   logic [23:0] uc_data = '0;

   logic        busy_o, done_o, M_o, P0_o, A_o, wr_o, ISR_o, ISL_o;
   logic [3:0]  S_o, v_o;
   logic [2:0]  adr_o;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   ralu_seq #(.UW(24), .DEPTH(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .entry_i(entry), .abort_i(abort),
      .P4_i(p4), .uc_we_i(uc_we), .uc_addr_i(uc_addr), .uc_data_i(uc_data),
      .busy_o(busy_o), .done_o(done_o), .S_o(S_o), .M_o(M_o), .P0_o(P0_o), .A_o(A_o),
      .v_o(v_o), .wr_o(wr_o), .adr_o(adr_o), .ISR_o(ISR_o), .ISL_o(ISL_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [23:0] mm [32];
   bit  m_run  = 1'b0;
   int  m_pc   = 0;
   int  m_cnt  = 0;
   bit  m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin : model
      logic [23:0] w;
      int op, target;
      if (!rst_n) begin
         m_run = 0; m_pc = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (!m_run) begin
            if (uc_we) mm[uc_addr] = uc_data;
            if (start) begin
               m_run = 1;
               m_pc  = int'(entry);
            end
         end else if (abort) begin
            m_run = 0;
         end else begin
            w      = mm[m_pc];
            op     = int'(w[7:5]);
            target = int'(w[4:0]);
            if (op == 0) m_pc = (m_pc + 1) % 32;
            else if (op == 1) m_pc = target;
            else if (op == 2) m_pc = p4 ? target : (m_pc + 1) % 32;
            else if (op == 3) m_pc = p4 ? (m_pc + 1) % 32 : target;
            else if (op == 4) begin
               m_cnt = target % 16;
               m_pc  = (m_pc + 1) % 32;
            end else if (op == 5) begin
               m_cnt = (m_cnt + 15) % 16;
               m_pc  = (m_cnt != 0) ? target : (m_pc + 1) % 32;
            end else begin
               m_run  = 0;
               m_done = 1;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin : compare
      logic [23:0] w;
      logic [16:0] exp_c, act_c;
      if (cmp_en) begin
         w     = mm[m_pc];
         exp_c = m_run ? {w[23:17], 1'b0, w[16:8]} : 17'd0;
         act_c = {S_o, M_o, P0_o, A_o, v_o, wr_o, adr_o, ISR_o, ISL_o};
         chk("ctrl_word", 32'(act_c), 32'(exp_c));
         chk("busy", 32'(busy_o), 32'(m_run));
         chk("done", 32'(done_o), 32'(m_done));
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [23:0] mk(input logic [3:0] s, input logic [2:0] v, input logic wr,
                                      input logic [2:0] adr, input logic [2:0] seq, input logic [4:0] tgt);
      return {s, 1'b0, 1'b0, 1'b0, v, wr, adr, 1'b0, 1'b0, seq, tgt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [4:0] a, input logic [23:0] d);
      uc_we = 1'b1; uc_addr = a; uc_data = d;
      tick();
      uc_we = 1'b0;
   endtask

   // Returns in the first RUN cycle
   task automatic start_prog(input logic [4:0] e);
      start = 1'b1; entry = e;
      tick();
      start = 1'b0;
   endtask

   logic [3:0] cap_s [64];
   int         cap_n;
   logic       cap_done;

   // Record S_o for every issued word, then the done_o of the cycle after; bounded
   task automatic capture(input string name);
      bit ended = 0;
      cap_n = 0; cap_done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!busy_o) begin
            cap_done = done_o;
            ended = 1;
            break;
         end
         cap_s[cap_n] = S_o;
         cap_n++;
      end
      chk({name, "_terminates"}, 32'(ended), 32'd1);
      tick();
   endtask

   logic [3:0] e38 [5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};

   initial begin
      #1 rst_n = 1'b0;
      #1;
      cmp_en = 1'b1;
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_done", 32'(done_o), 32'd0);
      chk("reset_ctrl", 32'({S_o, M_o, P0_o, A_o, v_o, wr_o, adr_o, ISR_o, ISL_o}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Fill the whole store so every word is defined
      for (int a = 0; a < 32; a++) write_word(5'(a), 24'($urandom));

      // Single END word with datapath fields
      write_word(5'd3, {4'b1001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'd5, 1'b0, 1'b0, 3'b110, 5'd0});
      start_prog(5'd3);
      @(negedge clk);
      chk("end_S", 32'(S_o), 32'h9);
      chk("end_v", 32'(v_o), 32'h1);
      chk("end_wr", 32'(wr_o), 32'd1);
      chk("end_adr", 32'(adr_o), 32'd5);
      chk("end_busy", 32'(busy_o), 32'd1);
      @(negedge clk);
      chk("end_done", 32'(done_o), 32'd1);
      chk("end_idle_ctrl", 32'({S_o, v_o, wr_o, adr_o, busy_o}), 32'd0);
      tick();
      @(negedge clk);
      chk("done_one_cycle", 32'(done_o), 32'd0);
      tick();

      // LDCNT 3 / DJNZ loop / END
      write_word(5'd0, mk(4'd0, 3'd0, 1'b0, 3'd0, 3'b100, 5'd3));
      write_word(5'd1, mk(4'd1, 3'd0, 1'b0, 3'd0, 3'b101, 5'd1));
      write_word(5'd2, mk(4'd2, 3'd0, 1'b0, 3'd0, 3'b110, 5'd0));
      start_prog(5'd0);
      capture("djnz");
      chk("djnz_len", 32'(cap_n), 32'd5);
      for (int i = 0; i < 5; i++) chk("djnz_seq", 32'(cap_s[i]), 32'(e38[i]));
      chk("djnz_done", 32'(cap_done), 32'd1);

      // JC taken and not taken
      write_word(5'd4, mk(4'd4, 3'd0, 1'b0, 3'd0, 3'b010, 5'd10));
      write_word(5'd5, mk(4'd5, 3'd0, 1'b0, 3'd0, 3'b110, 5'd0));
      write_word(5'd10, mk(4'd10, 3'd0, 1'b0, 3'd0, 3'b110, 5'd0));
      p4 = 1'b1;
      start_prog(5'd4);
      capture("jc1");
      chk("jc1_len", 32'(cap_n), 32'd2);
      chk("jc1_tgt", 32'(cap_s[1]), 32'd10);
      p4 = 1'b0;
      start_prog(5'd4);
      capture("jc0");
      chk("jc0_len", 32'(cap_n), 32'd2);
      chk("jc0_next", 32'(cap_s[1]), 32'd5);

      // Address wrap 31 -> 0
      write_word(5'd31, mk(4'd15, 3'd0, 1'b0, 3'd0, 3'b000, 5'd0));
      write_word(5'd0, mk(4'd0, 3'd0, 1'b0, 3'd0, 3'b110, 5'd0));
      start_prog(5'd31);
      capture("wrap");
      chk("wrap_len", 32'(cap_n), 32'd2);
      chk("wrap_first", 32'(cap_s[0]), 32'd15);
      chk("wrap_second", 32'(cap_s[1]), 32'd0);
      chk("wrap_done", 32'(cap_done), 32'd1);

      // Self-loop, ignored write and start while running, abort on 4th cycle
      write_word(5'd7, mk(4'd7, 3'd0, 1'b0, 3'd0, 3'b001, 5'd7));
      start_prog(5'd7);
      tick();
      uc_we = 1'b1; uc_addr = 5'd3; uc_data = 24'hFFFFFF;
      tick();
      uc_we = 1'b0; start = 1'b1; entry = 5'd3;
      tick();
      start = 1'b0; abort = 1'b1;
      chk("start_ignored_busy", 32'(busy_o), 32'd1);
      chk("start_ignored_S", 32'(S_o), 32'd7);
      tick();
      abort = 1'b0;
      chk("abort_idle", 32'(busy_o), 32'd0);
      chk("abort_no_done", 32'(done_o), 32'd0);
      tick();
      chk("abort_no_done_later", 32'(done_o), 32'd0);
      start_prog(5'd3);
      capture("kept");
      chk("kept_len", 32'(cap_n), 32'd1);
      chk("kept_S", 32'(cap_s[0]), 32'h9);

      // Reset in the middle of a long DJNZ loop, then rerun
      write_word(5'd20, mk(4'd4, 3'd0, 1'b0, 3'd0, 3'b100, 5'd15));
      write_word(5'd21, mk(4'd5, 3'd0, 1'b0, 3'd0, 3'b101, 5'd21));
      write_word(5'd22, mk(4'd6, 3'd0, 1'b0, 3'd0, 3'b110, 5'd0));
      start_prog(5'd20);
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      chk("rst_mid_ctrl", 32'({S_o, M_o, P0_o, A_o, v_o, wr_o, adr_o, ISR_o, ISL_o}), 32'd0);
      chk("rst_mid_done", 32'(done_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start_prog(5'd20);
      capture("rerun");
      chk("rerun_len", 32'(cap_n), 32'd17);
      chk("rerun_first", 32'(cap_s[0]), 32'd4);
      chk("rerun_loop", 32'(cap_s[1]), 32'd5);
      chk("rerun_last", 32'(cap_s[16]), 32'd6);
      chk("rerun_done", 32'(cap_done), 32'd1);

      // Randomized programs with random conditions, writes, restarts and aborts
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 4; k++) write_word(5'($urandom), 24'($urandom));
         start_prog(5'($urandom));
         for (int c = 0; c < 48; c++) begin
            p4      = 1'($urandom);
            start   = ($urandom % 8) == 0;
            entry   = 5'($urandom);
            uc_we   = ($urandom % 6) == 0;
            uc_addr = 5'($urandom);
            uc_data = 24'($urandom);
            abort   = ($urandom % 40) == 0;
            tick();
            if (!busy_o) break;
         end
         start = 1'b0; uc_we = 1'b0;
         if (busy_o) begin
            abort = 1'b1;
            tick();
         end
         abort = 1'b0;
         repeat (2) tick();
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ralu_seq.md
RALU_SEQ -- requirements
Module: ralu_seq

Interface
REQ-001 Parameter UW, default 24: microinstruction width in bits.
REQ-002 Parameter DEPTH, default 32: microprogram store depth (5-bit address).
REQ-003 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  begin executing at entry_i; honoured only in IDLE.
REQ-006 entry_i  in  5  microprogram entry address.
REQ-007 abort_i  in  1  synchronous abort of a running program.
REQ-008 P4_i  in  1  carry-out from the RALU, used as the branch condition.
REQ-009 uc_we_i / uc_addr_i / uc_data_i  in  1/5/UW  microprogram store write port.
REQ-010 busy_o  out  1  high while in RUN.
REQ-011 done_o  out  1  one-cycle pulse after END completes.
REQ-012 S_o[4], M_o, P0_o, A_o, v_o[4], wr_o, adr_o[3], ISR_o, ISL_o  out  as named  RALU control word.

Function
REQ-013 Word layout, MSB to LSB: S[23:20], M[19], P0[18], A[17], v[16:14], wr[13], adr[12:10], ISR[9], ISL[8], SEQ[7:5], TGT[4:0].
REQ-014 The FSM SHALL have states IDLE and RUN only.
REQ-015 In IDLE, all control outputs SHALL be 0 (RALU NOP: no register load, no RON write).
REQ-016 In RUN, control outputs SHALL decode combinationally from mem[upc]; v_o[2:0] = v field and v_o[3] = 0.
REQ-017 start_i high in IDLE at edge k: upc <= entry_i, state <= RUN; the entry word drives outputs in cycle k+1.
REQ-018 start_i while in RUN SHALL be ignored.
REQ-019 SEQ 000 NEXT: upc <= upc+1; 31 wraps to 0.
REQ-020 SEQ 001 JMP: upc <= TGT.
REQ-021 SEQ 010 JC: upc <= TGT if P4_i=1, else upc+1; P4_i is sampled at the edge ending the cycle.
REQ-022 SEQ 011 JNC: the inverse of JC.
REQ-023 SEQ 100 LDCNT: cnt <= TGT[3:0]; upc <= upc+1.
REQ-024 SEQ 101 DJNZ: cnt <= cnt-1 (4-bit wrap); upc <= TGT if (cnt-1) != 0, else upc+1. DJNZ at cnt=0 yields cnt=15 and a jump.
REQ-025 SEQ 110 END: the word's datapath fields are issued in that cycle; state <= IDLE; done_o = 1 in the following cycle only.
REQ-026 SEQ 111 (reserved) SHALL behave as END.
REQ-027 abort_i in RUN: state <= IDLE at the next edge and no done_o. abort_i takes priority over SEQ; abort_i in IDLE has no effect.
REQ-028 uc_we_i in IDLE: mem[uc_addr_i] <= uc_data_i at the edge. uc_we_i in RUN SHALL be ignored.
REQ-029 uc_we_i and start_i together in IDLE: the write completes, and execution starts using the updated contents.
REQ-030 busy_o SHALL be 1 exactly in the cycles in which a word is issued.

Reset
REQ-031 rst_n_i low SHALL immediately force: state=IDLE, upc=0, cnt=0, done_o=0, busy_o=0, all control outputs 0.
REQ-032 Microprogram store contents SHALL be unaffected by reset.
REQ-033 Reset asserted during RUN SHALL abandon the program with no done_o.

Structure
REQ-034 The following SHALL live in package ralu_seq_pkg: SEQ opcode constants, field bit positions, UW, DEPTH.
REQ-035 Sub-module ralu_useq_mem SHALL provide the 32xUW store with a synchronous write and an asynchronous read.
REQ-036 The FSM, upc, and cnt SHALL reside in ralu_seq.

Verification
REQ-037 Load word 3 = {S=1001, M=0, v=001, wr=1, adr=5, SEQ=END}, then start_i with entry 3 -> one cycle with S_o=1001, v_o=0001, wr_o=1, adr_o=5, busy_o=1; next cycle done_o=1 and outputs 0.
REQ-038 Word 0 = LDCNT TGT=3; word 1 = DJNZ TGT=1; word 2 = END; start at 0 -> upc sequence 0,1,1,1,2; busy_o high for 5 cycles.
REQ-039 Word 4 = JC TGT=10; word 5 = END; word 10 = END. With P4_i=1 -> upc 4,10. With P4_i=0 -> upc 4,5.
REQ-040 Word 31 = NEXT; word 0 = END; start at 31 -> upc 31,0, then done_o.
REQ-041 Self-loop JMP at word 7; abort_i pulsed on the 4th RUN cycle -> IDLE next cycle, done_o stays 0; uc_we_i during RUN leaves contents unchanged.
REQ-042 rst_n_i pulled low mid-DJNZ loop -> outputs 0 immediately; after release, a program started at the same entry reruns correctly from the unchanged microprogram contents.
